print_formatter: RTL and testbench

PRINT_FORMATTER -- requirements
Module: print_formatter

---
 rtl/print_fmt_pkg.sv | 41 ++++
 rtl/print_dec_digit.sv | 17 +
 rtl/print_formatter.sv | 191 +++++++++++++++++++
 tb/tb_print_formatter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/print_fmt_pkg.sv
// Shared constants, state encoding and character helpers for the print formatter.
package print_fmt_pkg;

    localparam logic [15:0] MEM_START = 16'hFEFF;

    localparam logic [15:0] CMD_BIN  = 16'h0002;
    localparam logic [15:0] CMD_CHAR = 16'h0008;
    localparam logic [15:0] CMD_DEC  = 16'h000A;
    localparam logic [15:0] CMD_HEX  = 16'h0010;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_LOW_A = 8'h61;
    localparam logic [7:0] ASCII_UP_A  = 8'h41;
    localparam logic [7:0] ASCII_SP    = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT,
        DIV,
        DONE
    } state_e;

    function automatic logic [7:0] hex_char(input logic [3:0] nib, input logic upper);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'd0, nib};
        end
        return (upper ? ASCII_UP_A : ASCII_LOW_A) + {4'd0, nib} - 8'd10;
    endfunction

    function automatic logic [15:0] dec_weight(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'd10000;
            4'd1:    return 16'd1000;
            4'd2:    return 16'd100;
            4'd3:    return 16'd10;
            default: return 16'd1;
        endcase
    endfunction

endpackage

// File: rtl/print_dec_digit.sv
// One repeated-subtraction step for a single decimal weight.
module print_dec_digit (
    input  logic [15:0] rem_i,
    input  logic [15:0] weight_i,
    input  logic [3:0]  digit_i,
    output logic [3:0]  digit_o,
    output logic [15:0] rem_o,
    output logic        done_o
);

    always_comb begin
        done_o  = rem_i < weight_i;
        rem_o   = done_o ? rem_i : rem_i - weight_i;
        digit_o = done_o ? digit_i : digit_i + 4'd1;
    end

endmodule

// File: rtl/print_formatter.sv
// Formats a 16-bit value as BIN/HEX/CHAR/DEC ASCII text, one character per
// valid/ready handshake.
module print_formatter
    import print_fmt_pkg::*;
#(
    parameter int unsigned HEX_UPPER = 0,
    parameter int unsigned DEC_PAD   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic [15:0] val,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [15:0] cmd_q, cmd_d;
    logic [15:0] val_q, val_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] rem_q, rem_d;
    logic [3:0]  digit_q, digit_d;
    logic        lead_q, lead_d;
    logic [7:0]  out_q, out_d;
    logic        valid_q, valid_d;

    logic [15:0] weight;
    logic [15:0] rem_nx;
    logic [3:0]  digit_nx;
    logic        div_done;
    logic        is_last;
    logic [3:0]  nib;
    logic [7:0]  fmt_char;
    logic [7:0]  dec_char;

    assign weight = dec_weight(idx_q);

    print_dec_digit u_dec_digit (
        .rem_i    (rem_q),
        .weight_i (weight),
        .digit_i  (digit_q),
        .digit_o  (digit_nx),
        .rem_o    (rem_nx),
        .done_o   (div_done)
    );

    always_comb begin
        case (cmd_q)
            CMD_BIN: is_last = (idx_q == 4'd15);
            CMD_HEX: is_last = (idx_q == 4'd3);
            CMD_DEC: is_last = (idx_q == 4'd4);
            default: is_last = 1'b1;
        endcase
    end

    always_comb begin
        case (idx_q[1:0])
            2'd0:    nib = val_q[15:12];
            2'd1:    nib = val_q[11:8];
            2'd2:    nib = val_q[7:4];
            default: nib = val_q[3:0];
        endcase
        case (cmd_q)
            CMD_BIN: fmt_char = val_q[4'd15 - idx_q] ? ASCII_0 + 8'd1 : ASCII_0;
            CMD_HEX: fmt_char = hex_char(nib, HEX_UPPER != 0);
            default: fmt_char = val_q[7:0];
        endcase
    end

    // Blank a zero only while no non-zero digit has been seen; the units digit is always printed.
    always_comb begin
        if (DEC_PAD != 0 && lead_q && digit_q == 4'd0 && idx_q != 4'd4) begin
            dec_char = ASCII_SP;
        end else begin
            dec_char = ASCII_0 + {4'd0, digit_q};
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        val_d   = val_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        digit_d = digit_q;
        lead_d  = lead_q;
        out_d   = out_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (cmd_valid) begin
                    cmd_d   = cmd;
                    val_d   = val;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                rem_d   = val_q;
                digit_d = '0;
                lead_d  = 1'b1;
                case (cmd_q)
                    CMD_BIN, CMD_HEX, CMD_CHAR: begin
                        state_d = EMIT;
                        out_d   = fmt_char;
                        valid_d = 1'b1;
                    end
                    CMD_DEC: state_d = DIV;
                    default: state_d = IDLE;
                endcase
            end
            EMIT: begin
                // A cycle with valid low after each handshake is the inter-character gap.
                if (valid_q) begin
                    if (char_ready) begin
                        valid_d = 1'b0;
                        if (is_last) begin
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 4'd1;
                            if (cmd_q == CMD_DEC) begin
                                state_d = DIV;
                                digit_d = '0;
                            end
                        end
                    end
                end else begin
                    valid_d = 1'b1;
                    out_d   = fmt_char;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = EMIT;
                    valid_d = 1'b1;
                    out_d   = dec_char;
                    if (digit_q != 4'd0) begin
                        lead_d = 1'b0;
                    end
                end else begin
                    rem_d   = rem_nx;
                    digit_d = digit_nx;
                end
            end
            DONE: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            val_q   <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            digit_q <= '0;
            lead_q  <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            digit_q <= digit_d;
            lead_q  <= lead_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = !cmd_ready;
    assign char_out   = out_q;
    assign char_valid = valid_q;

endmodule

// File: tb/tb_print_formatter.sv
// Bench for print_formatter: two parameterisations driven in parallel, table
// vectors, hand-written corner sequences and randomized commands.
module tb_print_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cmd = '0;
    logic [15:0] val = '0;
    logic        cmd_valid = 1'b0;
    logic        char_ready = 1'b0;
    logic        cmd_ready0, busy0, cv0;
    logic        cmd_ready1, busy1, cv1;
    logic [7:0]  co0, co1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    print_formatter #(.HEX_UPPER(0), .DEC_PAD(1)) dut0 (
        .clk(clk), .rst(rst), .cmd(cmd), .val(val), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready0), .char_out(co0), .char_valid(cv0),
        .char_ready(char_ready), .busy(busy0)
    );

    print_formatter #(.HEX_UPPER(1), .DEC_PAD(0)) dut1 (
        .clk(clk), .rst(rst), .cmd(cmd), .val(val), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready1), .char_out(co1), .char_valid(cv1),
        .char_ready(char_ready), .busy(busy1)
    );

    typedef struct {
        logic [15:0] c;
        logic [15:0] v;
        string       e0;
        string       e1;
        int          lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic string q2s(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h", q[i])};
        return s;
    endfunction

    task automatic cmp_q(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
        bit ok = (got.size() == exp.size());
        if (ok) begin
            foreach (got[i]) if (got[i] !== exp[i]) ok = 1'b0;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got chars [%s] expected [%s]", name, q2s(got), q2s(exp));
        end
    endtask

    function automatic void s2q(input string s, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endfunction

    // Reference: text a command should produce, straight from the formatting rules.
    function automatic void model(input logic [15:0] c, input logic [15:0] v,
                                  input bit upper, input bit pad, output logic [7:0] q[$]);
        string hx;
        int    w;
        int    d;
        int    idx;
        bit    lead;
        q  = {};
        hx = upper ? "0123456789ABCDEF" : "0123456789abcdef";
        case (c)
            16'h0002: for (int i = 15; i >= 0; i--) q.push_back(v[i] ? 8'h31 : 8'h30);
            16'h0010: begin
                for (int i = 3; i >= 0; i--) begin
                    idx = (int'(v) >> (4 * i)) & 15;
                    q.push_back(hx[idx]);
                end
            end
            16'h0008: q.push_back(v[7:0]);
            16'h000A: begin
                w    = 10000;
                lead = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    d = (int'(v) / w) % 10;
                    if (d != 0 || i == 4) lead = 1'b0;
                    q.push_back((lead && pad) ? 8'h20 : 8'h30 + 8'(d));
                    w = w / 10;
                end
            end
            default: q = {};
        endcase
    endfunction

    // mode 0: sink always ready; 1: random sink stalls and cmd_valid noise while busy;
    // 2: sink holds off the second character for three cycles.
    task automatic run_cmd(input logic [15:0] c, input logic [15:0] v, input int mode,
                           input string tag, output logic [7:0] g0[$],
                           output logic [7:0] g1[$], output int lat);
        bit         stall_prev = 1'b0;
        bit         hs_prev = 1'b0;
        bit         finished = 1'b0;
        logic [7:0] prev_c = '0;
        int         stall = 0;
        int         k;
        g0  = {};
        g1  = {};
        lat = -1;
        @(posedge clk); #1;
        k = 0;
        while (!cmd_ready0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, ":idle_before"}, int'(cmd_ready0), 1);
        cmd        = c;
        val        = v;
        cmd_valid  = 1'b1;
        char_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (k = 1; k <= 400 && !finished; k++) begin
            if (mode == 1 && !cmd_ready0) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd       = 16'h0008;
                val       = 16'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            case (mode)
                1:       char_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    char_ready = !(cv0 && g0.size() == 1 && stall < 3);
                    if (!char_ready) stall++;
                end
                default: char_ready = 1'b1;
            endcase
            @(negedge clk);
            if (cv0 != cv1) check({tag, ":valid_pair"}, int'(cv1), int'(cv0));
            if (cv0 && lat < 0) lat = k;
            if (stall_prev) begin
                check({tag, ":hold_valid"}, int'(cv0), 1);
                check({tag, ":hold_char"}, int'(co0), int'(prev_c));
            end
            if (hs_prev) check({tag, ":gap"}, int'(cv0), 0);
            if (cv0) check({tag, ":busy_when_valid"}, int'(busy0), 1);
            if (cv0 && char_ready) g0.push_back(co0);
            if (cv1 && char_ready) g1.push_back(co1);
            hs_prev    = cv0 && char_ready;
            stall_prev = cv0 && !char_ready;
            prev_c     = co0;
            if (cmd_ready0) begin
                if (lat < 0) lat = k;
                finished = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!finished) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout, cmd_ready still %0d after 400 cycles", tag, cmd_ready0);
        end
        cmd_valid  = 1'b0;
        char_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[8];
        logic [7:0]  g0[$], g1[$], e0[$], e1[$];
        int          lat;
        int          n;
        int          extra;
        logic [15:0] rc, rv;

        tbl[0] = '{16'h0010, 16'h00AF, "00af", "00AF", 2};
        tbl[1] = '{16'h000A, 16'd65535, "65535", "65535", 0};
        tbl[2] = '{16'h000A, 16'd0, "    0", "00000", 0};
        tbl[3] = '{16'h000A, 16'd42, "   42", "00042", 0};
        tbl[4] = '{16'h0002, 16'hA005, "1010000000000101", "1010000000000101", 2};
        tbl[5] = '{16'h0008, 16'h1241, "A", "A", 2};
        tbl[6] = '{16'h0007, 16'h1234, "", "", 2};
        tbl[7] = '{16'h000A, 16'd10009, "10009", "10009", 0};

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset:busy", int'(busy0), 0);
        check("reset:char_valid", int'(cv0), 0);
        check("reset:char_out", int'(co0), 0);
        rst = 1'b1;
        @(negedge clk);
        check("reset:cmd_ready_after", int'(cmd_ready0), 1);

        foreach (tbl[i]) begin
            run_cmd(tbl[i].c, tbl[i].v, 0, $sformatf("vec%0d", i), g0, g1, lat);
            s2q(tbl[i].e0, e0);
            s2q(tbl[i].e1, e1);
            cmp_q($sformatf("vec%0d:text_p0", i), g0, e0);
            cmp_q($sformatf("vec%0d:text_p1", i), g1, e1);
            if (tbl[i].lat != 0) check($sformatf("vec%0d:latency", i), lat, tbl[i].lat);
        end

        // Sink stalls on the second hex character
        run_cmd(16'h0010, 16'h1234, 2, "stall", g0, g1, lat);
        s2q("1234", e0);
        cmp_q("stall:text_p0", g0, e0);
        cmp_q("stall:text_p1", g1, e0);

        // Reset in the middle of a BIN command
        @(posedge clk); #1;
        cmd        = 16'h0002;
        val        = 16'hFFFF;
        cmd_valid  = 1'b1;
        char_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 100 && n < 5; k++) begin
            @(negedge clk);
            if (cv0 && char_ready) n++;
            if (n < 5) begin
                @(posedge clk); #1;
            end
        end
        check("abort:chars_before", n, 5);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort:char_valid", int'(cv0), 0);
        check("abort:busy", int'(busy0), 0);
        check("abort:char_out", int'(co0), 0);
        rst   = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (cv0 || cv1) extra++;
        end
        check("abort:no_more_chars", extra, 0);
        run_cmd(16'h0008, 16'h0041, 0, "after_abort", g0, g1, lat);
        s2q("A", e0);
        cmp_q("after_abort:text", g0, e0);

        // Randomized commands against the reference
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       rc = 16'h0002;
                1:       rc = 16'h0008;
                2:       rc = 16'h000A;
                3:       rc = 16'h0010;
                default: begin
                    rc = 16'($urandom);
                    if (rc == 16'h0002 || rc == 16'h0008 || rc == 16'h000A || rc == 16'h0010)
                        rc = 16'hFEFF;
                end
            endcase
            rv = 16'($urandom);
            run_cmd(rc, rv, 1, $sformatf("rnd%0d", i), g0, g1, lat);
            model(rc, rv, 1'b0, 1'b1, e0);
            model(rc, rv, 1'b1, 1'b0, e1);
            cmp_q($sformatf("rnd%0d:cmd%0h_val%0h_p0", i, rc, rv), g0, e0);
            cmp_q($sformatf("rnd%0d:cmd%0h_val%0h_p1", i, rc, rv), g1, e1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
